fp_unpack_norm: RTL and testbench
=================================

// Module: fp_unpack_norm
// PURPOSE
// - Operand front-end: inverse of the rounding stage. Takes a packed IEEE operand, classifies it, and normalizes subnormals.
// - Emits sign, signed biased exponent (EXP_WIDTH+2 bits), and significand with explicit hidden bit, ready for the datapath.
// - Subnormals are normalized iteratively by a shift FSM, at up to SHIFT_STEP bits/cycle; valid/ready on both sides.
// PARAMETERS
// - FP_FORMAT   FP32  operand format (fp_format_e); FP_WIDTH/EXP_WIDTH/MANT_WIDTH derived via fp_pkg functions
// - SHIFT_STEP  4     max left-shift per NORM cycle, 1..MANT_WIDTH
// PORTS
// - clk_i        in   1             clock
// - rst_i        in   1             synchronous, active-high reset
// - in_valid_i   in   1             operand valid
// - in_ready_o   out  1             operand accepted when in_valid_i & in_ready_o
// - op_i         in   FP_WIDTH      packed operand {sign, exp, mant}
// - out_valid_o  out  1             result valid
// - out_ready_i  in   1             result consumed when out_valid_o & out_ready_i
// - sign_o       out  1             operand sign
// - exp_o        out  EXP_WIDTH+2   signed biased exponent; <=0 for normalized subnormals
// - mant_o       out  MANT_WIDTH+1  significand, bit MANT_WIDTH = hidden/leading one
// - lz_o         out  $clog2(MANT_WIDTH+1)  normalization shift applied (0 unless subnormal)
// - is_zero_o, is_sub_o, is_inf_o, is_qnan_o, is_snan_o  out 1 each  class flags (one-hot or all 0 = normal)
// BEHAVIOUR
// - Reset: state=IDLE; out_valid_o=0; all data outputs and flags 0.
// - FSM IDLE -> (accept, subnormal) NORM -> HOLD; IDLE -> (accept, other) HOLD; HOLD -> (out_ready_i) IDLE, or
//   directly reloads if a new operand is accepted in the same cycle.
// - in_ready_o = (state==IDLE) | (state==HOLD & out_ready_i); combinational path from out_ready_i is permitted.
// - out_valid_o = (state==HOLD). Outputs are registered and held stable while out_valid_o & !out_ready_i.
// - Normal (0<e<2^EXP_WIDTH-1): exp_o=e, mant_o={1,m}, lz_o=0; 1-cycle latency (valid the cycle after accept).
// - Zero (e=0,m=0): exp_o=0, mant_o=0, is_zero_o=1; 1-cycle latency.
// - Inf/NaN (e=all ones): exp_o=2^EXP_WIDTH-1, mant_o={0,m}; m=0 -> is_inf_o; m[MSB]=1 -> is_qnan_o; else is_snan_o.
// - Subnormal (e=0,m!=0): working sig={0,m}, exp=1. Each NORM cycle: k = leading zeros in sig[MANT_WIDTH -: SHIFT_STEP]
//   (k<=SHIFT_STEP); sig<<=k, exp-=k, lz+=k. Leave NORM when sig[MANT_WIDTH]=1 (checked after shift).
//   Final: exp_o = 1-s, lz_o = s, s = leading-zero count of {0,m} in 1..MANT_WIDTH. Latency 1+ceil(s/SHIFT_STEP).
// - Arithmetic: exp is signed EXP_WIDTH+2, never overflows (min value 1-MANT_WIDTH). No rounding, no flags raised.
// - in_ready_o=0 throughout NORM; in_valid_i ignored while not ready. op_i sampled only on accept.
// - rst_i mid-NORM or mid-HOLD: pending operand discarded, returns to reset state next cycle; no output emitted.
// CONFIGURATION
// - FP_UNPACK_FAST_LZC_EN defined: subnormals normalized in the accept cycle by full LZC + barrel shifter;
//   NORM state not built; latency always 1; full throughput for all classes. SHIFT_STEP ignored.
// - Undefined: iterative NORM path above (area-lean default). Output values identical in both builds; only timing differs.
// TESTING (FP32, SHIFT_STEP=4)
// - op 0x3F800000 -> next cycle out_valid=1, sign=0, exp_o=127, mant_o=0x800000, lz=0, all class flags 0.
// - op 0x00000001 -> shifts 4,4,4,4,4,3; out_valid 7 cycles after accept; exp_o=-22 (10'h3EA), mant_o=0x800000, lz=23, is_sub=1;
//   with FP_UNPACK_FAST_LZC_EN same values after 1 cycle.
// - op 0x00400000 -> 2-cycle latency, exp_o=0, mant_o=0x800000, lz=1; op 0x80000000 -> is_zero=1, sign=1, exp_o=0, mant_o=0.
// - ops 0x7F800000/0xFF800000/0x7FC00000/0x7F800001 -> is_inf(sign 0)/is_inf(sign 1)/is_qnan/is_snan, exp_o=255.
// - Backpressure: out_ready=0 for 3 cycles -> outputs stable, in_ready=0; then out_ready=1 with 4 normals streaming -> accepted
//   on 4 consecutive cycles, results in order, no bubbles.
// - rst_i pulsed 2 cycles into NORM of 0x00000001 -> next cycle out_valid=0, in_ready=1; following op 0x3F800000 yields correct result.

Source files
------------

// File: rtl/fp_unpack_norm.sv
// -----------------------------------------------------------------------------
// fp_pkg / fp_unpack_norm
//
// Operand front-end for the FP datapath. Takes a packed IEEE operand, classifies
// it, and emits sign, signed biased exponent and significand with explicit
// hidden bit. Subnormals are normalized so that mant_o[MANT_WIDTH] is always the
// leading one for non-zero finite operands.
//
// Build option:
//   FP_UNPACK_FAST_LZC_EN  defined   -> subnormals normalized in the accept cycle
//                                       (full LZC + barrel shift), latency 1.
//                          undefined -> iterative NORM state, up to SHIFT_STEP
//                                       bits per cycle.
//   Output values are identical in both builds; only timing differs.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   in_valid_i / in_ready_o   operand handshake
//   op_i                      packed operand {sign, exp, mant}
//   out_valid_o / out_ready_i result handshake
//   sign_o                    operand sign
//   exp_o                     signed biased exponent, EXP_WIDTH+2 bits
//   mant_o                    significand, bit MANT_WIDTH = hidden/leading one
//   lz_o                      normalization shift applied (0 unless subnormal)
//   is_zero_o .. is_snan_o    one-hot class flags, all zero for normals
// -----------------------------------------------------------------------------

package fp_pkg;

    typedef enum logic [1:0] {
        FP32 = 2'd0,
        FP64 = 2'd1,
        FP16 = 2'd2,
        BF16 = 2'd3
    } fp_format_e;

    function automatic int unsigned exp_bits(fp_format_e fmt);
        case (fmt)
            FP64:    return 11;
            FP16:    return 5;
            BF16:    return 8;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned man_bits(fp_format_e fmt);
        case (fmt)
            FP64:    return 52;
            FP16:    return 10;
            BF16:    return 7;
            default: return 23;
        endcase
    endfunction

    function automatic int unsigned fp_width(fp_format_e fmt);
        return 1 + exp_bits(fmt) + man_bits(fmt);
    endfunction

endpackage

module fp_unpack_norm #(
    parameter fp_pkg::fp_format_e FP_FORMAT  = fp_pkg::FP32,
    parameter int unsigned        SHIFT_STEP = 4,
    localparam int unsigned EXP_WIDTH  = fp_pkg::exp_bits(FP_FORMAT),
    localparam int unsigned MANT_WIDTH = fp_pkg::man_bits(FP_FORMAT),
    localparam int unsigned FP_WIDTH   = fp_pkg::fp_width(FP_FORMAT),
    localparam int unsigned LZ_WIDTH   = $clog2(MANT_WIDTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [FP_WIDTH-1:0]   op_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  sign_o,
    output logic [EXP_WIDTH+1:0]  exp_o,
    output logic [MANT_WIDTH:0]   mant_o,
    output logic [LZ_WIDTH-1:0]   lz_o,
    output logic                  is_zero_o,
    output logic                  is_sub_o,
    output logic                  is_inf_o,
    output logic                  is_qnan_o,
    output logic                  is_snan_o
);

    localparam int unsigned EW = EXP_WIDTH + 2;

`ifdef FP_UNPACK_FAST_LZC_EN
    typedef enum logic [1:0] {IDLE, HOLD} state_e;
`else
    typedef enum logic [1:0] {IDLE, NORM, HOLD} state_e;
`endif

    state_e                state_q;
    logic                  sign_q;
    logic [EW-1:0]         exp_q;
    logic [MANT_WIDTH:0]   mant_q;
    logic [LZ_WIDTH-1:0]   lz_q;
    logic                  zero_q, sub_q, inf_q, qnan_q, snan_q;

    logic                  accept;

    // operand field decode
    logic                  op_sign;
    logic [EXP_WIDTH-1:0]  op_exp;
    logic [MANT_WIDTH-1:0] op_mant;
    logic                  exp_ones, exp_zero, mant_zero;

    // values loaded on accept
    state_e                ld_state;
    logic [EW-1:0]         ld_exp;
    logic [MANT_WIDTH:0]   ld_mant;
    logic [LZ_WIDTH-1:0]   ld_lz;
    logic                  ld_zero, ld_sub, ld_inf, ld_qnan, ld_snan;

    assign in_ready_o  = (state_q == IDLE) || ((state_q == HOLD) && out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q == HOLD);

    assign sign_o    = sign_q;
    assign exp_o     = exp_q;
    assign mant_o    = mant_q;
    assign lz_o      = lz_q;
    assign is_zero_o = zero_q;
    assign is_sub_o  = sub_q;
    assign is_inf_o  = inf_q;
    assign is_qnan_o = qnan_q;
    assign is_snan_o = snan_q;

    assign op_sign   = op_i[FP_WIDTH-1];
    assign op_exp    = op_i[FP_WIDTH-2 -: EXP_WIDTH];
    assign op_mant   = op_i[MANT_WIDTH-1:0];
    assign exp_ones  = &op_exp;
    assign exp_zero  = ~|op_exp;
    assign mant_zero = ~|op_mant;

`ifdef FP_UNPACK_FAST_LZC_EN
    logic [LZ_WIDTH-1:0]   sub_lz;
    logic [MANT_WIDTH:0]   sub_mant;
    logic [EW-1:0]         sub_exp;

    // Leading-zero count of {0,m}: the highest set bit of m wins because the
    // scan runs upward and later hits overwrite earlier ones.
    always_comb begin
        sub_lz = '0;
        for (int unsigned i = 0; i < MANT_WIDTH; i++) begin
            if (op_mant[i]) sub_lz = LZ_WIDTH'(MANT_WIDTH - i);
        end
        sub_mant = {1'b0, op_mant} << sub_lz;
        sub_exp  = EW'(1) - EW'(sub_lz);
    end
`else
    logic [LZ_WIDTH-1:0]   step_k;
    logic [MANT_WIDTH:0]   step_mant;
    logic                  step_found;

    // Leading zeros within the top SHIFT_STEP bits of the working significand.
    // An all-zero window shifts the full step; the leading one lies below the
    // window, so the shift can never overshoot it.
    always_comb begin
        step_k     = LZ_WIDTH'(SHIFT_STEP);
        step_found = 1'b0;
        for (int unsigned i = 0; i < SHIFT_STEP; i++) begin
            if (!step_found && mant_q[MANT_WIDTH - i]) begin
                step_k     = LZ_WIDTH'(i);
                step_found = 1'b1;
            end
        end
        step_mant = mant_q << step_k;
    end
`endif

    always_comb begin
        ld_state = HOLD;
        ld_exp   = '0;
        ld_mant  = '0;
        ld_lz    = '0;
        ld_zero  = 1'b0;
        ld_sub   = 1'b0;
        ld_inf   = 1'b0;
        ld_qnan  = 1'b0;
        ld_snan  = 1'b0;
        if (exp_ones) begin
            ld_exp  = {2'b00, op_exp};
            ld_mant = {1'b0, op_mant};
            ld_inf  = mant_zero;
            ld_qnan = op_mant[MANT_WIDTH-1];
            ld_snan = !mant_zero && !op_mant[MANT_WIDTH-1];
        end else if (exp_zero && mant_zero) begin
            ld_zero = 1'b1;
        end else if (exp_zero) begin
            ld_sub = 1'b1;
`ifdef FP_UNPACK_FAST_LZC_EN
            ld_exp  = sub_exp;
            ld_mant = sub_mant;
            ld_lz   = sub_lz;
`else
            // Subnormals carry exponent 1; NORM walks it down as it shifts.
            ld_state = NORM;
            ld_exp   = EW'(1);
            ld_mant  = {1'b0, op_mant};
`endif
        end else begin
            ld_exp  = {2'b00, op_exp};
            ld_mant = {1'b1, op_mant};
        end
    end

    // The output registers double as the NORM working registers; they are
    // only observable once the state reaches HOLD.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            lz_q    <= '0;
            zero_q  <= 1'b0;
            sub_q   <= 1'b0;
            inf_q   <= 1'b0;
            qnan_q  <= 1'b0;
            snan_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (accept) begin
                        state_q <= ld_state;
                        sign_q  <= op_sign;
                        exp_q   <= ld_exp;
                        mant_q  <= ld_mant;
                        lz_q    <= ld_lz;
                        zero_q  <= ld_zero;
                        sub_q   <= ld_sub;
                        inf_q   <= ld_inf;
                        qnan_q  <= ld_qnan;
                        snan_q  <= ld_snan;
                    end else if ((state_q == HOLD) && out_ready_i) begin
                        state_q <= IDLE;
                    end
                end
`ifndef FP_UNPACK_FAST_LZC_EN
                NORM: begin
                    mant_q <= step_mant;
                    exp_q  <= exp_q - EW'(step_k);
                    lz_q   <= lz_q + step_k;
                    if (step_mant[MANT_WIDTH]) state_q <= HOLD;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_unpack_norm.sv
module tb_fp_unpack_norm;

    localparam int STEP = 4;
`ifdef FP_UNPACK_FAST_LZC_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op;
    logic        out_valid;
    logic        out_ready;
    logic        sign;
    logic [9:0]  exp_v;
    logic [23:0] mant;
    logic [4:0]  lz;
    logic        is_zero, is_sub, is_inf, is_qnan, is_snan;
    logic [44:0] res;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign res = {sign, exp_v, mant, lz, is_zero, is_sub, is_inf, is_qnan, is_snan};

    fp_unpack_norm #(
        .SHIFT_STEP(STEP)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .op_i       (op),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .sign_o     (sign),
        .exp_o      (exp_v),
        .mant_o     (mant),
        .lz_o       (lz),
        .is_zero_o  (is_zero),
        .is_sub_o   (is_sub),
        .is_inf_o   (is_inf),
        .is_qnan_o  (is_qnan),
        .is_snan_o  (is_snan)
    );

    // Reference: IEEE binary32 field rules; subnormal shift from the position
    // of the most significant set mantissa bit.
    function automatic logic [44:0] model(input logic [31:0] x, output int lat);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        logic [9:0]  ex;
        logic [23:0] mt;
        logic [4:0]  lzv;
        logic [4:0]  fl;
        int          msb, sh;
        s = x[31]; e = x[30:23]; m = x[22:0];
        lat = 1; lzv = '0; fl = '0; ex = '0; mt = '0;
        if (e == 8'hFF) begin
            ex = 10'd255;
            mt = {1'b0, m};
            if (m == 0)     fl = 5'b00100;
            else if (m[22]) fl = 5'b00010;
            else            fl = 5'b00001;
        end else if (e == 0 && m == 0) begin
            fl = 5'b10000;
        end else if (e == 0) begin
            msb = 0;
            for (int b = 0; b < 23; b++) if (m[b]) msb = b;
            sh  = 23 - msb;
            ex  = 10'(1 - sh);
            mt  = 24'(m) << sh;
            lzv = 5'(sh);
            fl  = 5'b01000;
            lat = FAST ? 1 : 1 + (sh + STEP - 1) / STEP;
        end else begin
            ex = {2'b00, e};
            mt = {1'b1, m};
        end
        return {s, ex, mt, lzv, fl};
    endfunction

    function automatic logic [31:0] rand_op();
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom);
        case ($urandom_range(0, 5))
            0, 1: e = 8'($urandom_range(1, 254));
            2: begin e = 8'h00; m = '0; end
            3: begin e = 8'h00; if (m == 0) m = 23'd1; end
            4: begin e = 8'h00; m = 23'd1 << $urandom_range(0, 22); end
            default: begin e = 8'hFF; if ($urandom_range(0, 2) == 0) m = '0; end
        endcase
        return {s, e, m};
    endfunction

    function automatic logic [31:0] rand_normal();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
    endfunction

    // Entry and exit at 1 time unit after a rising edge.
    task automatic run_one(input logic [31:0] x, input string name);
        logic [44:0] exp_r;
        int          exp_lat, lat, w;
        exp_r = model(x, exp_lat);
        out_ready = 1'b1;
        op = x;
        in_valid = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL %s accept: in_ready=%b required 1", name, in_ready);
        else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = $urandom;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        n_total++;
        if (lat !== exp_lat) $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        else n_pass++;
        n_total++;
        if ({out_valid, res} !== {1'b1, exp_r})
            $display("FAIL %s result: got v=%b %h required v=1 %h", name, out_valid, res, exp_r);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL %s drain: out_valid=%b required 0", name, out_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = $urandom;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({out_valid, in_ready, res} !== {1'b0, 1'b1, 45'd0})
            $display("FAIL reset: got v=%b r=%b %h required v=0 r=1 0", out_valid, in_ready, res);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_classes();
        logic [31:0] ops [9];
        ops = '{32'h3F800000, 32'h00000001, 32'h00400000, 32'h80000000, 32'h7F800000,
                32'hFF800000, 32'h7FC00000, 32'h7F800001, 32'h807FFFFF};
        foreach (ops[i]) run_one(ops[i], $sformatf("class_%08h", ops[i]));
    endtask

    task automatic test_subnormal_exact();
        // Independent constants for the smallest subnormal.
        int lat_req;
        lat_req = FAST ? 1 : 7;
        out_ready = 1'b1; op = 32'h00000001; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c < lat_req; c++) begin
            n_total++;
            if (out_valid !== 1'b0) $display("FAIL sub_min early: cycle %0d out_valid=%b required 0", c, out_valid);
            else n_pass++;
            @(posedge clk); #1;
        end
        n_total++;
        if ({out_valid, exp_v, mant, lz, is_sub} !== {1'b1, 10'h3EA, 24'h800000, 5'd23, 1'b1})
            $display("FAIL sub_min: got v=%b e=%h m=%h lz=%0d sub=%b required v=1 e=3ea m=800000 lz=23 sub=1",
                     out_valid, exp_v, mant, lz, is_sub);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) run_one(rand_op(), $sformatf("rand_%0d", i));
    endtask

    task automatic test_backpressure();
        logic [31:0] a;
        logic [31:0] n [4];
        logic [44:0] ea;
        int          l;
        a = 32'h3F800000;
        foreach (n[i]) n[i] = rand_normal();
        ea = model(a, l);
        out_ready = 1'b0; op = a; in_valid = 1'b1;
        @(posedge clk); #1;
        op = n[0];
        for (int c = 0; c < 3; c++) begin
            n_total++;
            if ({out_valid, in_ready, res} !== {1'b1, 1'b0, ea})
                $display("FAIL bp_stall_%0d: got v=%b r=%b %h required v=1 r=0 %h", c, out_valid, in_ready, res, ea);
            else n_pass++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op = n[i]; in_valid = 1'b1;
            #1;
            n_total++;
            if ({out_valid, in_ready, res} !== {1'b1, 1'b1, (i == 0) ? ea : model(n[i-1], l)})
                $display("FAIL bp_stream_%0d: got v=%b r=%b %h required v=1 r=1 %h", i, out_valid, in_ready, res,
                         (i == 0) ? ea : model(n[i-1], l));
            else n_pass++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_total++;
        if ({out_valid, res} !== {1'b1, model(n[3], l)})
            $display("FAIL bp_last: got v=%b %h required v=1 %h", out_valid, res, model(n[3], l));
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL bp_drain: out_valid=%b required 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [44:0] q [$];
        logic [44:0] prev_res, want;
        logic        stall_prev, acc;
        int          sent, got, cyc, l;
        localparam int N = 80;
        sent = 0; got = 0; cyc = 0; stall_prev = 1'b0; prev_res = '0;
        in_valid = 1'b0;
        while (got < N && cyc < 6000) begin
            if (!in_valid && sent < N && $urandom_range(0, 3) != 0) begin
                op = rand_op(); in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (stall_prev) begin
                n_total++;
                if ({out_valid, res} !== {1'b1, prev_res})
                    $display("FAIL b2b_stable: got v=%b %h required v=1 %h", out_valid, res, prev_res);
                else n_pass++;
            end
            if (out_valid) begin
                n_total++;
                if (in_ready !== out_ready)
                    $display("FAIL b2b_ready: in_ready=%b required %b", in_ready, out_ready);
                else n_pass++;
            end
            if (out_valid && out_ready) begin
                want = (q.size() > 0) ? q.pop_front() : 'x;
                n_total++;
                if (res !== want) $display("FAIL b2b_result_%0d: got %h required %h", got, res, want);
                else n_pass++;
                got++;
            end
            stall_prev = out_valid && !out_ready;
            prev_res = res;
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(model(op, l));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) in_valid = 1'b0;
        end
        n_total++;
        if (got !== N) $display("FAIL b2b_count: got %0d results required %0d", got, N);
        else n_pass++;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_flight();
        logic exp_ov;
        // Mid-NORM reset (in the fast build the operand is already in HOLD).
        out_ready = 1'b1; op = 32'h00000001; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_ov = FAST;
        n_total++;
        if (out_valid !== exp_ov) $display("FAIL rst_norm_pre: out_valid=%b required %b", out_valid, exp_ov);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_total++;
        if ({out_valid, in_ready, res} !== {1'b0, 1'b1, 45'd0})
            $display("FAIL rst_norm: got v=%b r=%b %h required v=0 r=1 0", out_valid, in_ready, res);
        else n_pass++;
        repeat (8) begin
            @(posedge clk); #1;
            n_total++;
            if (out_valid !== 1'b0) $display("FAIL rst_norm_ghost: out_valid=%b required 0", out_valid);
            else n_pass++;
        end
        run_one(32'h3F800000, "post_rst_norm");
        // Mid-HOLD reset with the result stalled.
        out_ready = 1'b0; op = 32'h40490FDB; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_total++;
        if ({out_valid, in_ready, res} !== {1'b0, 1'b1, 45'd0})
            $display("FAIL rst_hold: got v=%b r=%b %h required v=0 r=1 0", out_valid, in_ready, res);
        else n_pass++;
        run_one(32'hC2F6E979, "post_rst_hold");
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0;
        test_reset();
        test_classes();
        test_subnormal_exact();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_flight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
